gray_sequencer: RTL and testbench
=================================

GRAY_SEQUENCER -- requirements
Module: gray_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, width of the binary index and Gray code.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-005 SHALL have port: start_bin  input  WIDTH  first binary index of the run, captured with start.
REQ-006 SHALL have port: len  input  WIDTH+1  number of codes to emit (0..2^WIDTH), captured with start.
REQ-007 SHALL have port: dir  input  1  0 = increment index, 1 = decrement index, captured with start.
REQ-008 SHALL have port: abort  input  1  terminates the current run.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the current code.
REQ-010 SHALL have port: out_valid  output  1  gray_out/bin_out hold a code for transfer.
REQ-011 SHALL have port: gray_out  output  WIDTH  Gray code of bin_out.
REQ-012 SHALL have port: bin_out  output  WIDTH  current binary index.
REQ-013 SHALL have port: busy  output  1  high while a run is in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse marking normal completion.

Function
REQ-015 SHALL implement FSM states IDLE, EMIT and DONE.
REQ-016 SHALL compute gray_out = bin_out XOR (bin_out >> 1) at all times, including when out_valid is 0.
REQ-017 In IDLE, start=1 with len!=0 SHALL load bin_out=start_bin, remain=len and dir, then enter EMIT; out_valid SHALL be 1 on the next cycle (latency 1).
REQ-018 In IDLE, start=1 with len=0 SHALL pulse done on the next cycle and return to IDLE without asserting out_valid.
REQ-019 In EMIT, out_valid and busy SHALL be 1; done SHALL be 0.
REQ-020 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, bin_out and gray_out SHALL stay stable.
REQ-022 On a transfer with remain>1: remain decrements and bin_out steps by +1 (dir=0) or -1 (dir=1), modulo 2^WIDTH (wrap-around: 2^WIDTH-1 -> 0 going up, 0 -> 2^WIDTH-1 going down).
REQ-023 On a transfer with remain=1: enter DONE, clear out_valid and leave bin_out unchanged.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=0, then enter IDLE; start in DONE SHALL be ignored.
REQ-025 start asserted in EMIT SHALL be ignored, and the captured start_bin/len/dir SHALL NOT change.
REQ-026 abort=1 in EMIT SHALL enter IDLE on the next cycle with out_valid=0, busy=0 and no done pulse; abort SHALL take precedence over a simultaneous transfer, and a transfer occurring in that cycle SHALL count as consumed.
REQ-027 abort in IDLE or DONE SHALL have no effect.
REQ-028 len=2^WIDTH SHALL emit every code exactly once.

Reset
REQ-029 rst=1 SHALL, at the next clock edge and in any state, force IDLE with out_valid=0, busy=0, done=0, bin_out=0 (so gray_out=0) and remain=0.
REQ-030 rst SHALL take precedence over start, abort and out_ready.
REQ-031 A run interrupted by rst SHALL NOT resume, and SHALL NOT produce a done pulse.

Verification
REQ-032 SHALL cover: rst asserted for 2 cycles -> out_valid=0, busy=0, done=0, gray_out=0, bin_out=0.
REQ-033 SHALL cover: WIDTH=4, start with start_bin=0, len=16, dir=0, out_ready=1 -> gray_out 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 on 16 consecutive cycles, then done=1 for one cycle.
REQ-034 SHALL cover: start_bin=E, len=4, dir=0 -> bin_out E,F,0,1 and gray_out 9,8,0,1 (up wrap); and start_bin=2, len=4, dir=1 -> bin_out 2,1,0,F and gray_out 3,1,0,8 (down wrap).
REQ-035 SHALL cover: out_ready held low for 3 cycles during the second code of a run -> gray_out held at that code for 3 cycles, the sequence continues unchanged afterward, and the total transfer count equals len.
REQ-036 SHALL cover: abort on the cycle of the 3rd transfer -> out_valid=0 on the next cycle, no done pulse, and start is accepted on the following cycle.
REQ-037 SHALL cover: start with len=0 -> done pulse after 1 cycle with no out_valid; and rst mid-run -> reset values on the next cycle.

Source files
------------

// File: rtl/gray_sequencer.sv
// Gray-code sequencer: emits a run of consecutive binary indices and their Gray codes.
// Latency: first code valid one cycle after an accepted start; one code per accepted transfer.
// Backpressure: out_ready low holds bin_out/gray_out stable; the index advances only on a transfer.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (wins over every other input)
//   start      one-cycle run request, sampled only while idle
//   start_bin  first binary index of the run (captured with start)
//   len        number of codes to emit, 0..2^WIDTH (captured with start)
//   dir        0 = count up, 1 = count down (captured with start)
//   abort      ends the current run immediately, with no done pulse
//   out_ready  consumer accepts the current code
//   out_valid  bin_out/gray_out hold a code for transfer
//   gray_out   Gray code of bin_out, always driven
//   bin_out    current binary index
//   busy       high while a run is in progress
//   done       one-cycle pulse on normal completion (also for a zero-length run)
module gray_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_bin,
    input  logic [WIDTH:0]   len,
    input  logic             dir,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   REMAIN_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    // remain is one bit wider than the index so a full 2^WIDTH run fits
    logic [WIDTH:0]   remain_q, remain_d;
    logic             dir_q, dir_d;

    logic             xfer;

    assign xfer = (state_q == EMIT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            remain_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        remain_d = remain_q;
        dir_d    = dir_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        bin_d    = start_bin;
                        remain_d = len;
                        dir_d    = dir;
                        state_d  = EMIT;
                    end else begin
                        // Zero-length run: report completion without ever
                        // presenting a code.
                        state_d  = DONE;
                    end
                end
            end

            EMIT: begin
                if (abort) begin
                    // Abort wins over a simultaneous transfer; that code is
                    // treated as consumed and the run is dropped.
                    remain_d = '0;
                    state_d  = IDLE;
                end else if (xfer) begin
                    if (remain_q == REMAIN_ONE) begin
                        // Last code taken: keep bin_out where it is.
                        remain_d = '0;
                        state_d  = DONE;
                    end else begin
                        remain_d = remain_q - REMAIN_ONE;
                        // Natural modulo-2^WIDTH wrap in both directions.
                        bin_d    = dir_q ? (bin_q - BIN_ONE) : (bin_q + BIN_ONE);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign bin_out   = bin_q;
    assign gray_out  = bin_q ^ (bin_q >> 1);

endmodule

// File: tb/tb_gray_sequencer.sv
module tb_gray_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] start_bin;
    logic [WIDTH:0]   len;
    logic             dir;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_bin (start_bin),
        .len       (len),
        .dir       (dir),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .gray_out  (gray_out),
        .bin_out   (bin_out),
        .busy      (busy),
        .done      (done)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_bin = '0; len = '0; dir = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (gray_out !== 4'h0) begin errors++; $display("FAIL reset_gray: got %h want 0", gray_out); end
        checks++; if (bin_out !== 4'h0) begin errors++; $display("FAIL reset_bin: got %h want 0", bin_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_sweep();
        logic [3:0] exp_g [16];
        exp_g = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        start = 1'b1; start_bin = 4'h0; len = 5'd16; dir = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || gray_out !== exp_g[i]) begin
                errors++;
                $display("FAIL sweep_code[%0d]: got valid=%b busy=%b done=%b gray=%h want 1 1 0 %h",
                         i, out_valid, busy, done, gray_out, exp_g[i]);
            end
            step();
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sweep_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid); end
        // start during DONE must be ignored
        start = 1'b1; len = 5'd3;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL sweep_done_len: got done=%b valid=%b want 0 0", done, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL start_in_done_ignored: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] up_b [4];
        logic [3:0] up_g [4];
        logic [3:0] dn_b [4];
        logic [3:0] dn_g [4];
        up_b = '{4'hE, 4'hF, 4'h0, 4'h1};
        up_g = '{4'h9, 4'h8, 4'h0, 4'h1};
        dn_b = '{4'h2, 4'h1, 4'h0, 4'hF};
        dn_g = '{4'h3, 4'h1, 4'h0, 4'h8};
        out_ready = 1'b1;
        start = 1'b1; start_bin = 4'hE; len = 5'd4; dir = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || bin_out !== up_b[i] || gray_out !== up_g[i]) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got valid=%b bin=%h gray=%h want 1 %h %h",
                         i, out_valid, bin_out, gray_out, up_b[i], up_g[i]);
            end
            step();
        end
        checks++; if (done !== 1'b1 || bin_out !== 4'h1) begin
            errors++; $display("FAIL wrap_up_done: got done=%b bin=%h want 1 1", done, bin_out); end
        step();
        start = 1'b1; start_bin = 4'h2; len = 5'd4; dir = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || bin_out !== dn_b[i] || gray_out !== dn_g[i]) begin
                errors++;
                $display("FAIL wrap_dn[%0d]: got valid=%b bin=%h gray=%h want 1 %h %h",
                         i, out_valid, bin_out, gray_out, dn_b[i], dn_g[i]);
            end
            step();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_dn_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        logic [3:0] exp_b [4];
        logic [3:0] exp_g [4];
        exp_b = '{4'h5, 4'h6, 4'h7, 4'h8};
        exp_g = '{4'h7, 4'h5, 4'h4, 4'hC};
        start = 1'b1; start_bin = 4'h5; len = 5'd4; dir = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        if (out_valid && out_ready) xfers++;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || gray_out !== 4'h5 || bin_out !== 4'h6) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b bin=%h gray=%h want 1 6 5",
                         i, out_valid, bin_out, gray_out);
            end
            if (out_valid && out_ready) xfers++;
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || bin_out !== exp_b[i] || gray_out !== exp_g[i]) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got valid=%b bin=%h gray=%h want 1 %h %h",
                         i, out_valid, bin_out, gray_out, exp_b[i], exp_g[i]);
            end
            if (out_valid && out_ready) xfers++;
            step();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
        checks++; if (xfers !== 4) begin errors++; $display("FAIL stall_xfer_count: got %0d want 4", xfers); end
        step();
    endtask

    task automatic test_start_in_emit();
        logic [3:0] exp_b [3];
        exp_b = '{4'h8, 4'h7, 4'h6};
        start = 1'b1; start_bin = 4'h8; len = 5'd3; dir = 1'b1; out_ready = 1'b1;
        step();
        // A second request with different parameters must not disturb the run.
        start = 1'b1; start_bin = 4'h0; len = 5'd16; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || bin_out !== exp_b[i]) begin
                errors++;
                $display("FAIL start_in_emit[%0d]: got valid=%b bin=%h want 1 %h", i, out_valid, bin_out, exp_b[i]);
            end
            step();
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || bin_out !== 4'h6) begin
            errors++; $display("FAIL start_in_emit_done: got done=%b bin=%h want 1 6", done, bin_out); end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1; start_bin = 4'h0; len = 5'd8; dir = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        // third transfer cycle
        checks++; if (bin_out !== 4'h2) begin errors++; $display("FAIL abort_pre_bin: got %h want 2", bin_out); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done); end
        start = 1'b1; start_bin = 4'h3; len = 5'd2; dir = 1'b0;
        step();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1 || bin_out !== 4'h3 || done !== 1'b0) begin
            errors++; $display("FAIL abort_restart: got valid=%b bin=%h done=%b want 1 3 0", out_valid, bin_out, done); end
        step();
        step();
        checks++; if (done !== 1'b1 || bin_out !== 4'h4) begin
            errors++; $display("FAIL abort_restart_done: got done=%b bin=%h want 1 4", done, bin_out); end
        // abort during DONE has no effect on the pulse sequence
        abort = 1'b1;
        step();
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_in_done: got done=%b valid=%b want 0 0", done, out_valid); end
        // abort in IDLE alongside start: start still accepted
        start = 1'b1; start_bin = 4'hA; len = 5'd1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++; if (out_valid !== 1'b1 || bin_out !== 4'hA) begin
            errors++; $display("FAIL abort_in_idle: got valid=%b bin=%h want 1 a", out_valid, bin_out); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_in_idle_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_len_zero();
        start = 1'b1; start_bin = 4'h7; len = 5'd0; out_ready = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL len0_done: got done=%b valid=%b busy=%b want 1 0 0", done, out_valid, busy); end
        step();
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL len0_after: got done=%b valid=%b want 0 0", done, out_valid); end
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1; start_bin = 4'h9; len = 5'd10; dir = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (bin_out !== 4'hB) begin errors++; $display("FAIL rst_pre_bin: got %h want b", bin_out); end
        // reset wins over a simultaneous start, abort and transfer
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bin_out !== 4'h0 || gray_out !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b busy=%b done=%b bin=%h gray=%h want 0 0 0 0 0",
                     out_valid, busy, done, bin_out, gray_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_resume[%0d]: got valid=%b done=%b want 0 0", i, out_valid, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_wrap();
        test_backpressure();
        test_start_in_emit();
        test_abort();
        test_len_zero();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
